// File: rtl/writeback_unit.sv
// writeback_unit
//   Last pipeline stage. Owns the register file write port, merging
//   single-cycle ALU results (buffered in a small FIFO) with load responses
//   from data memory, which cannot be stalled and so always win arbitration.
//   Load data is byte/halfword extracted and sign/zero-extended here.
//   A busy mask of outstanding loads is kept for decode-stage stalls.
//
// Ports
//   clk, rst_n                  clock, async active-low reset
//   alu_valid/alu_ready         ALU result handshake (ready = FIFO not full)
//   alu_rd, alu_data            ALU destination and result
//   load_issue_valid/_rd        decode issued a load to rd this cycle
//   mem_rsp_valid/_rd/_data     load response (raw aligned word)
//   mem_rsp_funct3/_offset      load type and byte offset
//   rf_write_enable/addr/data   registered register file write port
//   busy_mask                   bit i set while a load to x_i is outstanding
module writeback_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 5,
  parameter int ALU_FIFO_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_rd,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  load_issue_valid,
  input  logic [ADDR_WIDTH-1:0] load_issue_rd,
  input  logic                  mem_rsp_valid,
  input  logic [ADDR_WIDTH-1:0] mem_rsp_rd,
  input  logic [DATA_WIDTH-1:0] mem_rsp_data,
  input  logic [2:0]            mem_rsp_funct3,
  input  logic [1:0]            mem_rsp_offset,
  output logic                  rf_write_enable,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [31:0]           busy_mask
);

  localparam int PW = (ALU_FIFO_DEPTH > 1) ? $clog2(ALU_FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(ALU_FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;

  // ---------------------------------------------------------------------
  // ALU result FIFO
  // ---------------------------------------------------------------------
  logic [EW-1:0] fifo_q [ALU_FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          push, pop, fifo_empty;

  // Ready is a pure function of state, so no input-to-ready path exists.
  assign alu_ready  = (count != FULL_CNT);
  assign fifo_empty = (count == '0);

  // Results for x0 are handshaken but dropped rather than occupying a slot.
  assign push = alu_valid && alu_ready && (alu_rd != '0);
  // Memory responses cannot be back-pressured, so the FIFO only drains
  // on cycles without one.
  assign pop  = !mem_rsp_valid && !fifo_empty;

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= {alu_rd, alu_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      // Depth is a power of two, so pointers wrap naturally.
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Load data extraction
  // ---------------------------------------------------------------------
  function automatic logic [DATA_WIDTH-1:0] load_extract(
    input logic [DATA_WIDTH-1:0] d,
    input logic [2:0]            f3,
    input logic [1:0]            off
  );
    logic [7:0]  b;
    logic [15:0] h;
    b = d[8*off +: 8];
    // Halfwords are assumed aligned; offset[0] is don't-care.
    h = d[16*off[1] +: 16];
    case (f3)
      3'b000:  load_extract = {{(DATA_WIDTH-8){b[7]}}, b};
      3'b001:  load_extract = {{(DATA_WIDTH-16){h[15]}}, h};
      3'b100:  load_extract = {{(DATA_WIDTH-8){1'b0}}, b};
      3'b101:  load_extract = {{(DATA_WIDTH-16){1'b0}}, h};
      default: load_extract = d;  // LW and unused encodings
    endcase
  endfunction

  // ---------------------------------------------------------------------
  // Arbitration and registered write port
  // ---------------------------------------------------------------------
  logic                  sel_valid;
  logic [ADDR_WIDTH-1:0] sel_rd;
  logic [DATA_WIDTH-1:0] sel_data;

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (mem_rsp_valid) begin
      sel_valid = 1'b1;
      sel_rd    = mem_rsp_rd;
      sel_data  = load_extract(mem_rsp_data, mem_rsp_funct3, mem_rsp_offset);
    end else if (pop) begin
      sel_valid = 1'b1;
      {sel_rd, sel_data} = fifo_q[rd_ptr];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else if (sel_valid && (sel_rd != '0)) begin
      rf_write_enable <= 1'b1;
      rf_write_addr   <= sel_rd;
      rf_write_data   <= sel_data;
    end else begin
      // Address/data hold when idle to avoid needless toggling.
      rf_write_enable <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Load scoreboard
  // ---------------------------------------------------------------------
  logic [31:0] busy_q, busy_nxt;

  always_comb begin
    busy_nxt = busy_q;
    if (mem_rsp_valid) busy_nxt[mem_rsp_rd] = 1'b0;
    // Applied after the clear so a same-cycle reissue keeps the bit set.
    if (load_issue_valid) busy_nxt[load_issue_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_nxt;
  end

  assign busy_mask = busy_q;

endmodule

// File: tb/tb_writeback_unit.sv
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_rd = '0;
  logic [31:0] alu_data = '0;
  logic        load_issue_valid = 1'b0;
  logic [4:0]  load_issue_rd = '0;
  logic        mem_rsp_valid = 1'b0;
  logic [4:0]  mem_rsp_rd = '0;
  logic [31:0] mem_rsp_data = '0;
  logic [2:0]  mem_rsp_funct3 = '0;
  logic [1:0]  mem_rsp_offset = '0;
  logic        rf_write_enable;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic [31:0] busy_mask;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  writeback_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ALU_FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .load_issue_valid(load_issue_valid), .load_issue_rd(load_issue_rd),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rd(mem_rsp_rd), .mem_rsp_data(mem_rsp_data),
    .mem_rsp_funct3(mem_rsp_funct3), .mem_rsp_offset(mem_rsp_offset),
    .rf_write_enable(rf_write_enable), .rf_write_addr(rf_write_addr),
    .rf_write_data(rf_write_data), .busy_mask(busy_mask)
  );

  typedef struct packed {
    logic        av;   logic [4:0] ard;  logic [31:0] adat;
    logic        iv;   logic [4:0] ird;
    logic        mv;   logic [4:0] mrd;  logic [31:0] mdat;
    logic [2:0]  f3;   logic [1:0] off;
    logic        ewe;  logic [4:0] eaddr; logic [31:0] edat;
    logic [31:0] ebusy; logic      erdy;
  } vec_t;

  localparam int NV = 26;
  vec_t vec [NV];

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; alu_rd = 0; alu_data = 0;
    load_issue_valid = 0; load_issue_rd = 0;
    mem_rsp_valid = 0; mem_rsp_rd = 0; mem_rsp_data = 0;
    mem_rsp_funct3 = 0; mem_rsp_offset = 0;
  endtask

  task automatic chk_port(input string tag, input int idx, input logic we,
                          input logic [4:0] addr, input logic [31:0] data);
    chk({tag, " we"}, idx, {31'b0, rf_write_enable}, {31'b0, we});
    chk({tag, " addr"}, idx, {27'b0, rf_write_addr}, {27'b0, addr});
    chk({tag, " data"}, idx, rf_write_data, data);
  endtask

  function automatic vec_t mk(
    input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic iv, input logic [4:0] ird,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat,
    input logic [2:0] f3, input logic [1:0] off,
    input logic ewe, input logic [4:0] eaddr, input logic [31:0] edat,
    input logic [31:0] ebusy, input logic erdy);
    vec_t v;
    v.av = av; v.ard = ard; v.adat = adat; v.iv = iv; v.ird = ird;
    v.mv = mv; v.mrd = mrd; v.mdat = mdat; v.f3 = f3; v.off = off;
    v.ewe = ewe; v.eaddr = eaddr; v.edat = edat; v.ebusy = ebusy; v.erdy = erdy;
    return v;
  endfunction

  localparam logic [31:0] B9 = 32'h0000_0200;

  initial begin
    //            av ard adat          iv ird  mv mrd mdat          f3    off   we addr data          busy  rdy
    vec[0]  = mk(0, 0,  0,             0, 0,   1, 7,  32'h80FF_FF00, 3'b000, 2'd3, 1, 7,  32'hFFFF_FF80, 0,    1); // LB
    vec[1]  = mk(0, 0,  0,             0, 0,   1, 7,  32'h80FF_FF00, 3'b100, 2'd3, 1, 7,  32'h0000_0080, 0,    1); // LBU
    vec[2]  = mk(0, 0,  0,             0, 0,   1, 7,  32'h80FF_FF00, 3'b101, 2'd2, 1, 7,  32'h0000_80FF, 0,    1); // LHU
    vec[3]  = mk(0, 0,  0,             0, 0,   1, 7,  32'h80FF_FF00, 3'b001, 2'd2, 1, 7,  32'hFFFF_80FF, 0,    1); // LH hi
    vec[4]  = mk(0, 0,  0,             0, 0,   1, 8,  32'h80FF_FF00, 3'b001, 2'd1, 1, 8,  32'hFFFF_FF00, 0,    1); // LH off[0] ignored
    vec[5]  = mk(0, 0,  0,             0, 0,   1, 31, 32'h80FF_FF00, 3'b010, 2'd0, 1, 31, 32'h80FF_FF00, 0,    1); // LW
    vec[6]  = mk(0, 0,  0,             0, 0,   1, 3,  32'h80FF_FF00, 3'b011, 2'd1, 1, 3,  32'h80FF_FF00, 0,    1); // 011 as LW
    vec[7]  = mk(0, 0,  0,             0, 0,   1, 4,  32'h80FF_FF00, 3'b100, 2'd1, 1, 4,  32'h0000_00FF, 0,    1); // LBU b1
    vec[8]  = mk(0, 0,  0,             0, 0,   1, 4,  32'h80FF_FF00, 3'b000, 2'd0, 1, 4,  32'h0000_0000, 0,    1); // LB b0
    vec[9]  = mk(0, 0,  0,             0, 0,   0, 0,  0,             3'b000, 2'd0, 0, 4,  32'h0000_0000, 0,    1); // idle hold
    vec[10] = mk(0, 0,  0,             0, 0,   1, 0,  32'hDEAD_BEEF, 3'b010, 2'd0, 0, 4,  32'h0000_0000, 0,    1); // load x0
    vec[11] = mk(1, 0,  32'hDEAD_BEEF, 0, 0,   0, 0,  0,             3'b000, 2'd0, 0, 4,  32'h0000_0000, 0,    1); // alu x0
    vec[12] = mk(0, 0,  0,             0, 0,   0, 0,  0,             3'b000, 2'd0, 0, 4,  32'h0000_0000, 0,    1); // nothing queued
    vec[13] = mk(1, 5,  32'h1234_5678, 0, 0,   0, 0,  0,             3'b000, 2'd0, 0, 4,  32'h0000_0000, 0,    1); // alu push
    vec[14] = mk(0, 0,  0,             0, 0,   0, 0,  0,             3'b000, 2'd0, 1, 5,  32'h1234_5678, 0,    1); // alu write
    vec[15] = mk(0, 0,  0,             0, 0,   0, 0,  0,             3'b000, 2'd0, 0, 5,  32'h1234_5678, 0,    1);
    vec[16] = mk(0, 0,  0,             1, 9,   0, 0,  0,             3'b000, 2'd0, 0, 5,  32'h1234_5678, B9,   1); // issue x9
    vec[17] = mk(0, 0,  0,             0, 0,   0, 0,  0,             3'b000, 2'd0, 0, 5,  32'h1234_5678, B9,   1);
    vec[18] = mk(0, 0,  0,             0, 0,   0, 0,  0,             3'b000, 2'd0, 0, 5,  32'h1234_5678, B9,   1);
    vec[19] = mk(0, 0,  0,             0, 0,   1, 9,  32'hA5A5_A5A5, 3'b010, 2'd0, 1, 9,  32'hA5A5_A5A5, 0,    1); // rsp clears
    vec[20] = mk(0, 0,  0,             1, 9,   1, 9,  32'h0000_0011, 3'b010, 2'd0, 1, 9,  32'h0000_0011, B9,   1); // set wins
    vec[21] = mk(0, 0,  0,             0, 0,   1, 9,  32'h0000_0022, 3'b010, 2'd0, 1, 9,  32'h0000_0022, 0,    1);
    vec[22] = mk(0, 0,  0,             1, 0,   0, 0,  0,             3'b000, 2'd0, 0, 9,  32'h0000_0022, 0,    1); // issue x0
    vec[23] = mk(0, 0,  0,             1, 1,   0, 0,  0,             3'b000, 2'd0, 0, 9,  32'h0000_0022, 32'h2, 1);
    vec[24] = mk(0, 0,  0,             0, 0,   1, 2,  32'h0000_007F, 3'b100, 2'd0, 1, 2,  32'h0000_007F, 32'h2, 1); // other rd
    vec[25] = mk(0, 0,  0,             0, 0,   1, 1,  32'h0000_0000, 3'b010, 2'd0, 1, 1,  32'h0000_0000, 0,    1);

    // Reset state
    #12;
    chk_port("rst", 0, 1'b0, 5'd0, 32'h0);
    chk("rst busy", 0, busy_mask, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst ready", 0, {31'b0, alu_ready}, 32'h1);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      alu_valid = vec[i].av; alu_rd = vec[i].ard; alu_data = vec[i].adat;
      load_issue_valid = vec[i].iv; load_issue_rd = vec[i].ird;
      mem_rsp_valid = vec[i].mv; mem_rsp_rd = vec[i].mrd; mem_rsp_data = vec[i].mdat;
      mem_rsp_funct3 = vec[i].f3; mem_rsp_offset = vec[i].off;
      step();
      chk_port("vec", i, vec[i].ewe, vec[i].eaddr, vec[i].edat);
      chk("vec busy", i, busy_mask, vec[i].ebusy);
      chk("vec ready", i, {31'b0, alu_ready}, {31'b0, vec[i].erdy});
    end
    idle_inputs();

    // FIFO fill while loads hold the write port
    mem_rsp_valid = 1; mem_rsp_funct3 = 3'b010;
    mem_rsp_rd = 10; mem_rsp_data = 32'hA000_000A;
    alu_valid = 1; alu_rd = 1; alu_data = 32'h101;
    step();
    chk_port("full c0", 0, 1'b1, 5'd10, 32'hA000_000A);
    chk("full c0 ready", 0, {31'b0, alu_ready}, 32'h1);
    mem_rsp_rd = 11; mem_rsp_data = 32'hA000_000B;
    alu_rd = 2; alu_data = 32'h202;
    step();
    chk_port("full c1", 1, 1'b1, 5'd11, 32'hA000_000B);
    chk("full c1 ready", 1, {31'b0, alu_ready}, 32'h0);
    mem_rsp_rd = 12; mem_rsp_data = 32'hA000_000C;
    alu_rd = 3; alu_data = 32'h303;
    step();
    chk_port("full c2", 2, 1'b1, 5'd12, 32'hA000_000C);
    chk("full c2 ready", 2, {31'b0, alu_ready}, 32'h0);
    mem_rsp_rd = 13; mem_rsp_data = 32'hA000_000D;
    step();
    chk_port("full c3", 3, 1'b1, 5'd13, 32'hA000_000D);
    chk("full c3 ready", 3, {31'b0, alu_ready}, 32'h0);
    mem_rsp_valid = 0;
    step();
    chk_port("drain x1", 4, 1'b1, 5'd1, 32'h101);
    chk("drain ready", 4, {31'b0, alu_ready}, 32'h1);
    step();  // x3 is accepted at this edge while x2 drains
    chk_port("drain x2", 5, 1'b1, 5'd2, 32'h202);
    alu_valid = 0;
    step();
    chk_port("drain x3", 6, 1'b1, 5'd3, 32'h303);
    step();
    chk("drain empty", 7, {31'b0, rf_write_enable}, 32'h0);
    chk("drain ready2", 7, {31'b0, alu_ready}, 32'h1);

    // Reset with two buffered ALU results and a busy bit
    mem_rsp_valid = 1; mem_rsp_rd = 0; mem_rsp_data = 0;
    alu_valid = 1; alu_rd = 20; alu_data = 32'h2020;
    load_issue_valid = 1; load_issue_rd = 15;
    step();
    alu_rd = 21; alu_data = 32'h2121; load_issue_valid = 0;
    step();
    chk("pre-rst ready", 0, {31'b0, alu_ready}, 32'h0);
    chk("pre-rst busy", 0, busy_mask, 32'h0000_8000);
    idle_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk_port("midrst", 0, 1'b0, 5'd0, 32'h0);
    chk("midrst busy", 0, busy_mask, 32'h0);
    step();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post-rst we", i, {31'b0, rf_write_enable}, 32'h0);
      chk("post-rst busy", i, busy_mask, 32'h0);
      chk("post-rst ready", i, {31'b0, alu_ready}, 32'h1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_unit.md
Name: writeback_unit

Overview:
- Final pipeline stage that owns the register file write port.
- Merges single-cycle ALU results with asynchronous load responses from the data memory interface, and sign/zero-extends load data.
- Keeps a load scoreboard (busy mask) that the decode stage uses for stalls.
- Drives write_enable / write_addr / write_data of the 32x32 register file directly.

Parameters:
- DATA_WIDTH, 32, width of result and register data.
- ADDR_WIDTH, 5, register index width.
- ALU_FIFO_DEPTH, 2, ALU result buffer entries (power of two, >=2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU result offered.
- alu_ready  output  1  FIFO can accept; equals !fifo_full, with no combinational path from any input.
- alu_rd  input  ADDR_WIDTH  destination register of ALU result.
- alu_data  input  DATA_WIDTH  ALU result.
- load_issue_valid  input  1  decode issued a load this cycle.
- load_issue_rd  input  ADDR_WIDTH  destination of issued load.
- mem_rsp_valid  input  1  load response present; cannot be stalled.
- mem_rsp_rd  input  ADDR_WIDTH  destination of load response.
- mem_rsp_data  input  DATA_WIDTH  raw aligned memory word.
- mem_rsp_funct3  input  3  load type.
- mem_rsp_offset  input  2  byte offset of load address.
- rf_write_enable  output  1  register file write strobe.
- rf_write_addr  output  ADDR_WIDTH  register file write address.
- rf_write_data  output  DATA_WIDTH  register file write data.
- busy_mask  output  32  bit i = 1 means a load to x_i is outstanding.

Behaviour:
- Reset (async assert, sync release): FIFO empty; busy_mask=0; rf_write_enable=0; rf_write_addr=0; rf_write_data=0; alu_ready=1 after release. Resetting mid-operation discards buffered ALU results and pending busy bits.
- ALU push: alu_valid && alu_ready at an edge enqueues {rd,data}. If alu_rd==0, the result is accepted but not enqueued (discarded).
- Arbitration, once per cycle: a mem response has absolute priority. If mem_rsp_valid, select the load. Otherwise, if the FIFO is non-empty, pop the head and select it. Otherwise there is no write.
- Outputs are registered. The selection in cycle N appears on rf_write_* in cycle N+1 and is written into the register file at the end of N+1.
- Latency: load 1 cycle. ALU minimum 2 cycles (enqueue edge, then selection). There is no bypass.
- No write is ever issued to x0. rf_write_enable is forced 0 if the selected rd==0, and rf_write_addr/data hold their previous values when enable is 0.
- Load extraction, byte b = data[8*offset+:8], half h = data[16*offset[1]+:16]:
  - 000 LB: sign-extend b.
  - 001 LH: sign-extend h.
  - 010 LW: whole word.
  - 100 LBU: zero-extend b.
  - 101 LHU: zero-extend h.
  - 011/110/111: treated as LW.
  - Misalignment is handled upstream; offset[0] is ignored for halfwords.
- Scoreboard:
  - load_issue_valid && rd!=0 sets busy[rd].
  - mem_rsp_valid clears busy[mem_rsp_rd] at the same edge the load is selected.
  - Set and clear of the same rd in one cycle: set wins.
  - busy[0] is constant 0.
- Ordering: FIFO is strict FIFO. Decode stalls on busy_mask, so an ALU result never targets a busy register; this is not checked here.
- FIFO full: alu_ready=0 while count==ALU_FIFO_DEPTH. Ready rises the cycle after a pop. A full FIFO with continuous mem_rsp_valid stays full indefinitely, which is legal.

Test Plan:
- Reset release, then ALU push rd=5, data=0x1234_5678 at cycle 0 → rf_write_enable=1, addr=5, data=0x12345678 in cycle 2; all outputs 0 during reset.
- mem_rsp LB, offset=3, data=0x80FF_FF00, rd=7 → cycle+1: write x7=0xFFFF_FF80; same rsp with LBU → 0x0000_0080; LHU offset=2 → 0x0000_80FF.
- Load issue rd=9, then mem_rsp rd=9 three cycles later → busy_mask bit9=1 for exactly 3 cycles, clears on the rsp edge; issue+rsp on rd=9 in the same cycle → bit9 stays 1.
- mem_rsp_valid held 4 cycles while pushing ALU rd=1,2,3 → FIFO fills, alu_ready=0 after 2 pushes; loads written first, then x1, x2, x3 in order; alu_ready returns to 1.
- ALU rd=0, data=0xDEAD_BEEF, and mem_rsp rd=0 → rf_write_enable never asserts; busy_mask[0]=0.
- Assert rst_n=0 with 2 FIFO entries and busy bits set → immediately empty FIFO, busy_mask=0, rf_write_enable=0; no stale writes after release.
